// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: operation encoding and the shared entry-update function
// used by the latch_bank storage entries and the reference model.
package latch_bank_pkg;

   // Widest entry the shared update function can handle.
   localparam int unsigned LB_MAX_WIDTH = 64;

   typedef logic [LB_MAX_WIDTH-1:0] lb_word_t;

   typedef enum logic [1:0] {
      LB_LOAD = 2'b00,
      LB_SET  = 2'b01,
      LB_CLR  = 2'b10,
      LB_TGL  = 2'b11
   } lb_op_t;

   // New entry value for one operation applied to the old value.
   function automatic lb_word_t lb_apply(input lb_op_t op, input lb_word_t old, input lb_word_t data);
      lb_word_t res;
      res = old;
      case (op)
         LB_LOAD: res = data;
         LB_SET:  res = old | data;
         LB_CLR:  res = old & ~data;
         LB_TGL:  res = old ^ data;
         default: res = old;
      endcase
      return res;
   endfunction

endpackage : latch_bank_pkg

// File: rtl/latch_bank_entry.sv
// latch_bank_entry: one WIDTH-bit storage word with async reset. Exposes the
// value it will hold after the next edge (for write-first reads) and a flag
// that the pending update actually changes the stored value.
module latch_bank_entry
   import latch_bank_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  lb_op_t           op,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] nxt_c,
   output logic             changed_c
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] applied;

   // Next value: operation result when enabled, otherwise hold.
   always_comb begin
      applied   = WIDTH'(lb_apply(op, lb_word_t'(q), lb_word_t'(data)));
      nxt_c     = q;
      changed_c = 1'b0;
      if (en) begin
         nxt_c     = applied;
         changed_c = (applied != q);
      end
   end

   // Storage register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= nxt_c;
      end
   end

endmodule : latch_bank_entry

// File: rtl/latch_bank.sv
// latch_bank: DEPTH x WIDTH clocked storage bank with load/set/clear/toggle
// commands, a registered write-first read port and sticky dirty flags.
// Optional feature: define LATCH_BANK_QBAR_EN to add the rd_qbar output.
module latch_bank
   import latch_bank_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  lb_op_t           cmd_op,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
`ifdef LATCH_BANK_QBAR_EN
   output logic [WIDTH-1:0] rd_qbar,
`endif
   output logic [DEPTH-1:0] dirty,
   input  logic [DEPTH-1:0] dirty_clr
);

   logic             accept;
   logic [DEPTH-1:0] ent_en;
   logic [DEPTH-1:0] ent_changed;
   logic [WIDTH-1:0] ent_nxt [DEPTH];
   logic [WIDTH-1:0] rd_nxt;

   // Hold is the only source of backpressure.
   assign cmd_ready = ~hold;
   assign accept    = cmd_valid & ~hold;

   // Storage entries, one apply-enable decoded per address.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign ent_en[i] = accept & (cmd_addr == AW'(i));

      latch_bank_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk       (clk),
         .reset     (reset),
         .en        (ent_en[i]),
         .op        (cmd_op),
         .data      (cmd_data),
         .nxt_c     (ent_nxt[i]),
         .changed_c (ent_changed[i])
      );
   end

   // Read the post-edge value so same-cycle commands are visible (write-first).
   assign rd_nxt = ent_nxt[rd_addr];

   // Registered read port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_nxt;
      end
   end

`ifdef LATCH_BANK_QBAR_EN
   // Complement output registered alongside rd_data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_qbar <= '1;
      end else begin
         rd_qbar <= ~rd_nxt;
      end
   end
`endif

   // Sticky dirty flags; a change in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dirty <= '0;
      end else begin
         dirty <= (dirty & ~dirty_clr) | ent_changed;
      end
   end

endmodule : latch_bank

// File: doc/latch_bank.md
# latch_bank

Parametrised bank of DEPTH clocked storage entries, each WIDTH bits, replacing single-word SR/D latch primitives in the decompressor datapath. Each entry supports load, bit-set, bit-clear and bit-toggle operations through one valid/ready command port. The bank has a registered read port with write-first bypass and per-entry sticky dirty flags. It holds decoder configuration and status words that were previously kept in free-running latches.

## Interface
- WIDTH, 32, bits per entry (≥1)
- DEPTH, 8, number of entries (≥2, power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  freeze: stalls command acceptance (latch-EN-low equivalent)
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid && ready
- cmd_op  in  2  operation (LOAD/SET/CLR/TGL)
- cmd_addr  in  AW  target entry
- cmd_data  in  WIDTH  load value or bit mask
- rd_addr  in  AW  read address, sampled every cycle
- rd_data  out  WIDTH  registered read data
- rd_qbar  out  WIDTH  ~rd_data (only with LATCH_BANK_QBAR_EN)
- dirty  out  DEPTH  sticky per-entry change flags
- dirty_clr  in  DEPTH  per-entry dirty clear mask, one-cycle pulses

## Operation
- cmd_ready = ~hold, purely combinational; no other source of backpressure.
- Accepted command updates entry[cmd_addr] at the next rising edge:
  - LOAD: entry = cmd_data
  - SET: entry = entry | cmd_data
  - CLR: entry = entry & ~cmd_data
  - TGL: entry = entry ^ cmd_data
- Non-accepted cycles (no valid, or hold=1): all entries hold their values.
- Read uses write-first bypass. rd_data at edge N+1 = value entry[rd_addr] takes at edge N+1, including any command accepted in cycle N to the same address.
- dirty[i] is set at the edge where an accepted command changes entry[i]. New value ≠ old value is required; a no-op SET/CLR/LOAD leaves dirty unchanged.
- dirty[i] is cleared at the edge following dirty_clr[i]=1.
- Same cycle set and clear of dirty[i]: set wins, so dirty[i]=1.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

## Timing
- Reset (asynchronous assert, released synchronously by the environment): all entries = 0, rd_data = 0, rd_qbar = all ones, dirty = 0. cmd_ready follows hold during reset, but commands are ignored while reset=1.
- Command-to-entry latency: 1 cycle. Command-to-rd_data latency for the same address: 1 cycle (bypass).
- Read latency: rd_addr in cycle N → rd_data after edge N+1.
- Back-to-back commands to the same entry accumulate. Example: SET 0x0F then TGL 0x03 yields 0x0C.
- Reset asserted mid-operation: an in-flight accepted command is discarded, and state is zero immediately, not at the next edge.
- hold rising in the same cycle as cmd_valid: the command is not accepted, and the source must keep it asserted.

## Configuration
- LATCH_BANK_QBAR_EN defined: rd_qbar port exists, registered alongside rd_data as its bitwise complement, with reset value all ones.
- Not defined: rd_qbar port and its register are absent; all other behaviour is identical.

## Structure
- latch_bank_pkg:
  - typedef enum logic [1:0] lb_op_t {LB_LOAD=2'b00, LB_SET=2'b01, LB_CLR=2'b10, LB_TGL=2'b11}
  - function lb_apply(op, old, data) returning the new entry value, shared with the bench's reference model.
- Sub-module latch_bank_entry: one WIDTH register with async reset, an apply-enable and a changed output driving its dirty bit. It is instantiated DEPTH times by generate.

## Test plan
- Reset, then read all addresses → rd_data=0, dirty=0, rd_qbar=32'hFFFFFFFF.
- LOAD addr3=0xA5A5_0000, SET 0x0000_00FF, CLR 0xA000_000F, TGL 0x0000_0101 → entry3 = 0x05A5_01F1, dirty[3]=1, others 0.
- rd_addr=5 held while LOAD addr5=0x1234_5678 is accepted → rd_data=0x1234_5678 one cycle after acceptance (bypass).
- hold=1 with cmd_valid=1 (LOAD addr0=0xFFFF_FFFF) for 3 cycles → cmd_ready=0, entry0 stays 0. Release hold → accepted in one cycle, entry0=0xFFFF_FFFF.
- dirty[2]=1, then dirty_clr[2]=1 the same cycle as an accepted TGL addr2=0x1 → dirty[2]=1. A later dirty_clr alone → 0. A LOAD of an identical value → stays 0.
- Assert reset between acceptance of LOAD addr7=0xDEAD_BEEF and the next edge → entry7=0 and dirty=0 after release.
